// File: rtl/change_dispenser.sv
// Greedy coin payout sequencer with per-denomination inventory; one PICK cycle per coin plus ISSUE until ack.
// Holds coin_req/coin_sel until the hopper acks; refunds arriving while busy are dropped, not queued.
module change_dispenser #(
  parameter int COIN_A   = 50,
  parameter int COIN_B   = 20,
  parameter int COIN_C   = 10,
  parameter int CNT_W    = 8,
  parameter int INIT_CNT = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             refund_req,
  input  logic [9:0]       refund_amt,
  input  logic             coin_ack,
  input  logic             maintenance,
  input  logic             restock,
  input  logic [1:0]       restock_sel,
  input  logic [CNT_W-1:0] restock_qty,
  output logic             coin_req,
  output logic [1:0]       coin_sel,
  output logic             busy,
  output logic             done,
  output logic [9:0]       short_amt,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c,
  output logic [2:0]       state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PICK  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;

  localparam logic [9:0]       VAL_A    = 10'(COIN_A);
  localparam logic [9:0]       VAL_B    = 10'(COIN_B);
  localparam logic [9:0]       VAL_C    = 10'(COIN_C);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_CNT);

  logic [9:0] remaining;
  logic       elig_a;
  logic       elig_b;
  logic       elig_c;
  logic [9:0] issue_val;
  logic       do_restock;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // An empty denomination is never eligible, so inventory cannot underflow.
  assign elig_a = (VAL_A <= remaining) && (cnt_a != '0);
  assign elig_b = (VAL_B <= remaining) && (cnt_b != '0);
  assign elig_c = (VAL_C <= remaining) && (cnt_c != '0);

  always_comb begin
    issue_val = VAL_C;
    case (coin_sel)
      2'd0:    issue_val = VAL_A;
      2'd1:    issue_val = VAL_B;
      default: issue_val = VAL_C;
    endcase
  end

  assign do_restock = (state == S_IDLE) && maintenance && restock && (restock_sel != 2'd3);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      coin_req  <= 1'b0;
      coin_sel  <= 2'd0;
      done      <= 1'b0;
      short_amt <= '0;
      remaining <= '0;
      cnt_a     <= CNT_INIT;
      cnt_b     <= CNT_INIT;
      cnt_c     <= CNT_INIT;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (refund_req) begin
            remaining <= refund_amt;
            state     <= S_PICK;
          end
          if (do_restock) begin
            case (restock_sel)
              2'd0:    cnt_a <= sat_add(cnt_a, restock_qty);
              2'd1:    cnt_b <= sat_add(cnt_b, restock_qty);
              default: cnt_c <= sat_add(cnt_c, restock_qty);
            endcase
          end
        end
        S_PICK: begin
          if (remaining == '0) begin
            short_amt <= '0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (elig_a || elig_b || elig_c) begin
            coin_sel <= elig_a ? 2'd0 : (elig_b ? 2'd1 : 2'd2);
            coin_req <= 1'b1;
            state    <= S_ISSUE;
          end else begin
            short_amt <= remaining;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_ISSUE: begin
          if (coin_ack) begin
            remaining <= remaining - issue_val;
            coin_req  <= 1'b0;
            state     <= S_PICK;
            case (coin_sel)
              2'd0:    cnt_a <= cnt_a - 1'b1;
              2'd1:    cnt_b <= cnt_b - 1'b1;
              default: cnt_c <= cnt_c - 1'b1;
            endcase
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: hopper model acks coins and scores them against an expected-coin queue.
module tb_change_dispenser;
  logic       clk = 1'b0;
  logic       rst;
  logic       refund_req;
  logic [9:0] refund_amt;
  logic       coin_ack;
  logic       maintenance;
  logic       restock;
  logic [1:0] restock_sel;
  logic [7:0] restock_qty;
  logic       coin_req;
  logic [1:0] coin_sel;
  logic       busy;
  logic       done;
  logic [9:0] short_amt;
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;
  logic [7:0] cnt_c;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_coins[$];
  logic [9:0] exp_short[$];

  always #5 clk = ~clk;

  change_dispenser dut (
    .clk(clk), .rst(rst), .refund_req(refund_req), .refund_amt(refund_amt),
    .coin_ack(coin_ack), .maintenance(maintenance), .restock(restock),
    .restock_sel(restock_sel), .restock_qty(restock_qty), .coin_req(coin_req),
    .coin_sel(coin_sel), .busy(busy), .done(done), .short_amt(short_amt),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c), .state(state)
  );

  task automatic do_reset();
    rst = 1'b0; refund_req = 1'b0; refund_amt = '0; coin_ack = 1'b0;
    maintenance = 1'b0; restock = 1'b0; restock_sel = '0; restock_qty = '0;
    exp_coins.delete(); exp_short.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_refund(input logic [9:0] amt);
    @(negedge clk);
    refund_amt = amt; refund_req = 1'b1;
    @(negedge clk);
    refund_req = 1'b0;
  endtask

  // Hopper model: acks each request after dly extra cycles and scores coins and the final short amount.
  task automatic serve(input int dly);
    int waited = 0;
    int cyc = 0;
    bit got_done = 0;
    logic [1:0] sel0 = '0;
    logic [1:0] exp_c;
    logic [9:0] exp_s;
    while (!got_done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      coin_ack = 1'b0;
      if (done) begin
        got_done = 1;
        exp_s = (exp_short.size() > 0) ? exp_short.pop_front() : 10'h3ff;
        n_checks++;
        if (short_amt !== exp_s) begin
          n_fail++; $display("FAIL short_amt: got %0d expected %0d", short_amt, exp_s);
        end
        n_checks++;
        if (exp_coins.size() != 0) begin
          n_fail++; $display("FAIL coin_count: %0d expected coins never issued", exp_coins.size());
        end
      end else if (coin_req) begin
        if (waited == 0) sel0 = coin_sel;
        else begin
          n_checks++;
          if (coin_sel !== sel0) begin
            n_fail++; $display("FAIL coin_sel_stable: got %0d expected %0d", coin_sel, sel0);
          end
        end
        if (waited >= dly) begin
          coin_ack = 1'b1;
          exp_c = (exp_coins.size() > 0) ? exp_coins.pop_front() : 2'd3;
          n_checks++;
          if (coin_sel !== exp_c) begin
            n_fail++; $display("FAIL coin_sel: got %0d expected %0d", coin_sel, exp_c);
          end
          waited = 0;
        end else waited++;
      end
    end
    coin_ack = 1'b0;
    if (!got_done) begin
      n_checks++; n_fail++;
      $display("FAIL payout_timeout: no done within 2000 cycles");
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (cnt_a !== 8'd20) begin n_fail++; $display("FAIL rst_cnt_a: got %0d expected 20", cnt_a); end
    n_checks++; if (cnt_b !== 8'd20) begin n_fail++; $display("FAIL rst_cnt_b: got %0d expected 20", cnt_b); end
    n_checks++; if (cnt_c !== 8'd20) begin n_fail++; $display("FAIL rst_cnt_c: got %0d expected 20", cnt_c); end
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d expected 0", state); end
    n_checks++;
    if ({coin_req, done, busy} !== 3'b000 || short_amt !== 10'd0) begin
      n_fail++; $display("FAIL rst_outputs: req/done/busy=%b short=%0d expected 000/0", {coin_req, done, busy}, short_amt);
    end
  endtask

  task automatic test_basic_80();
    do_reset();
    exp_coins.push_back(2'd0); exp_coins.push_back(2'd1); exp_coins.push_back(2'd2);
    exp_short.push_back(10'd0);
    start_refund(10'd80);
    serve(0);
    n_checks++;
    if ({cnt_a, cnt_b, cnt_c} !== {8'd19, 8'd19, 8'd19}) begin
      n_fail++; $display("FAIL cnt_after_80: got %0d/%0d/%0d expected 19/19/19", cnt_a, cnt_b, cnt_c);
    end
  endtask

  task automatic test_empty_a();
    do_reset();
    for (int i = 0; i < 20; i++) exp_coins.push_back(2'd0);
    exp_short.push_back(10'd0);
    start_refund(10'd1000);
    serve(0);
    n_checks++; if (cnt_a !== 8'd0) begin n_fail++; $display("FAIL drain_a: got %0d expected 0", cnt_a); end
    for (int i = 0; i < 5; i++) exp_coins.push_back(2'd1);
    exp_short.push_back(10'd0);
    start_refund(10'd100);
    serve(0);
    n_checks++; if (cnt_b !== 8'd15) begin n_fail++; $display("FAIL cnt_b_after_100: got %0d expected 15", cnt_b); end
    n_checks++; if (cnt_a !== 8'd0) begin n_fail++; $display("FAIL cnt_a_held_0: got %0d expected 0", cnt_a); end
  endtask

  task automatic test_short_and_zero();
    do_reset();
    exp_coins.push_back(2'd1); exp_coins.push_back(2'd2);
    exp_short.push_back(10'd5);
    start_refund(10'd35);
    serve(0);
    @(negedge clk);
    refund_amt = 10'd0; refund_req = 1'b1;
    @(negedge clk);
    refund_req = 1'b0;
    n_checks++;
    if (state !== 3'd1 || done !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL zero_cycle1: state=%0d done=%b busy=%b expected 1/0/1", state, done, busy);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || coin_req !== 1'b0 || short_amt !== 10'd0) begin
      n_fail++; $display("FAIL zero_cycle2: done=%b req=%b short=%0d expected 1/0/0", done, coin_req, short_amt);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || state !== 3'd0) begin
      n_fail++; $display("FAIL zero_cycle3: done=%b state=%0d expected 0/0", done, state);
    end
  endtask

  task automatic test_slow_ack();
    do_reset();
    exp_coins.push_back(2'd0); exp_coins.push_back(2'd1); exp_coins.push_back(2'd2);
    exp_short.push_back(10'd0);
    start_refund(10'd80);
    @(negedge clk);
    refund_amt = 10'd500; refund_req = 1'b1;
    @(negedge clk);
    refund_req = 1'b0;
    serve(4);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (state !== 3'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_req_ignored: state=%0d busy=%b expected 0/0", state, busy);
    end
    n_checks++;
    if ({cnt_a, cnt_b, cnt_c} !== {8'd19, 8'd19, 8'd19}) begin
      n_fail++; $display("FAIL cnt_after_slow: got %0d/%0d/%0d expected 19/19/19", cnt_a, cnt_b, cnt_c);
    end
  endtask

  task automatic test_reset_mid_issue();
    int cyc = 0;
    bit saw_done = 0;
    do_reset();
    start_refund(10'd80);
    while (!coin_req && cyc < 20) begin @(negedge clk); cyc++; end
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    n_checks++; if (cnt_a !== 8'd19) begin n_fail++; $display("FAIL mid_cnt_a: got %0d expected 19", cnt_a); end
    cyc = 0;
    while (!coin_req && cyc < 20) begin @(negedge clk); cyc++; end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (state !== 3'd0 || coin_req !== 1'b0 || busy !== 1'b0 || cnt_a !== 8'd20) begin
      n_fail++; $display("FAIL async_abort: state=%0d req=%b busy=%b cnt_a=%0d expected 0/0/0/20", state, coin_req, busy, cnt_a);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (done) saw_done = 1; end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got done=1 expected 0"); end
  endtask

  task automatic test_restock();
    do_reset();
    maintenance = 1'b1; restock = 1'b1; restock_sel = 2'd2; restock_qty = 8'd250;
    @(negedge clk);
    n_checks++; if (cnt_c !== 8'd255) begin n_fail++; $display("FAIL restock_sat: got %0d expected 255", cnt_c); end
    restock_sel = 2'd3; restock_qty = 8'd7;
    @(negedge clk);
    n_checks++;
    if ({cnt_a, cnt_b, cnt_c} !== {8'd20, 8'd20, 8'd255}) begin
      n_fail++; $display("FAIL restock_sel3: got %0d/%0d/%0d expected 20/20/255", cnt_a, cnt_b, cnt_c);
    end
    maintenance = 1'b0; restock_sel = 2'd0; restock_qty = 8'd5;
    @(negedge clk);
    n_checks++; if (cnt_a !== 8'd20) begin n_fail++; $display("FAIL restock_no_maint: got %0d expected 20", cnt_a); end
    maintenance = 1'b1;
    @(negedge clk);
    restock = 1'b0; maintenance = 1'b0;
    n_checks++; if (cnt_a !== 8'd25) begin n_fail++; $display("FAIL restock_a: got %0d expected 25", cnt_a); end
    exp_coins.push_back(2'd2); exp_short.push_back(10'd0);
    start_refund(10'd10);
    maintenance = 1'b1; restock = 1'b1; restock_sel = 2'd1; restock_qty = 8'd5;
    @(negedge clk);
    maintenance = 1'b0; restock = 1'b0;
    n_checks++; if (cnt_b !== 8'd20) begin n_fail++; $display("FAIL restock_busy: got %0d expected 20", cnt_b); end
    serve(0);
    n_checks++; if (cnt_c !== 8'd254) begin n_fail++; $display("FAIL cnt_c_after_10: got %0d expected 254", cnt_c); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    exp_coins.push_back(2'd1); exp_short.push_back(10'd0);
    @(negedge clk);
    refund_amt = 10'd20; refund_req = 1'b1;
    maintenance = 1'b1; restock = 1'b1; restock_sel = 2'd1; restock_qty = 8'd3;
    @(negedge clk);
    refund_req = 1'b0; maintenance = 1'b0; restock = 1'b0;
    n_checks++; if (cnt_b !== 8'd23) begin n_fail++; $display("FAIL same_cycle_restock: got %0d expected 23", cnt_b); end
    serve(0);
    n_checks++; if (cnt_b !== 8'd22) begin n_fail++; $display("FAIL same_cycle_payout: got %0d expected 22", cnt_b); end
    exp_coins.push_back(2'd0); exp_coins.push_back(2'd0); exp_coins.push_back(2'd2);
    exp_short.push_back(10'd3);
    start_refund(10'd113);
    serve(1);
    n_checks++; if (cnt_a !== 8'd18) begin n_fail++; $display("FAIL b2b_cnt_a: got %0d expected 18", cnt_a); end
  endtask

  initial begin
    test_reset();
    test_basic_80();
    test_empty_a();
    test_short_and_zero();
    test_slow_ack();
    test_reset_mid_issue();
    test_restock();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
